// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter: FSM state
// and bus-owner encodings plus a counter-width helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2,
    StResp = 2'd3
  } bus_state_e;

  typedef enum logic {
    OwnerInst = 1'b0,
    OwnerData = 1'b1
  } bus_owner_e;

  // Bits needed to hold values 0..limit; at least one bit.
  function automatic int unsigned cnt_width(int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Transaction watchdog: counts enabled cycles and flags expiry on the cycle
// the count reaches TimeoutCycles. TimeoutCycles = 0 disables it.
module bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = cnt_width(TimeoutCycles);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry counts the current cycle, so the abort happens within the budget.
  assign expire_o = (TimeoutCycles != 0) && en_i && ((32'(cnt_q) + 32'd1) == TimeoutCycles);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the MEM-stage data port,
// one latched request at a time, with per-port stalls and a hang watchdog.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    inst_en_i,
  input  logic [ADDR_WIDTH-1:0]   inst_addr_i,
  output logic [DATA_WIDTH-1:0]   inst_rdata_o,
  output logic                    inst_done_o,
  output logic                    inst_stall_o,
  input  logic                    data_en_i,
  input  logic [DATA_WIDTH/8-1:0] data_wen_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_done_o,
  output logic                    data_stall_o,
  output logic                    bus_req_o,
  output logic                    bus_wr_o,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr_o,
  output logic [DATA_WIDTH-1:0]   bus_wdata_o,
  input  logic                    bus_addr_ok_i,
  input  logic                    bus_data_ok_i,
  input  logic [DATA_WIDTH-1:0]   bus_rdata_i,
  output logic                    bus_err_o
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  bus_state_e            state_q, state_d;
  bus_owner_e            owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [StrbWidth-1:0]  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  err_q, err_d;
  logic                  expire;

  bus_watchdog #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (state_q == StIdle),
    .en_i    ((state_q == StAddr) || (state_q == StData)),
    .expire_o(expire)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (data_en_i) begin
          owner_d = OwnerData;
          addr_d  = data_addr_i;
          wen_d   = data_wen_i;
          wdata_d = data_wdata_i;
          state_d = StAddr;
        end else if (inst_en_i) begin
          owner_d = OwnerInst;
          addr_d  = inst_addr_i;
          wen_d   = '0;
          wdata_d = '0;
          state_d = StAddr;
        end
      end
      StAddr, StData: begin
        if (expire) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (owner_q == OwnerData) data_rdata_d = '0;
          else                      inst_rdata_d = '0;
        end else if (state_q == StAddr) begin
          if (bus_addr_ok_i) state_d = StData;
        end else if (bus_data_ok_i) begin
          state_d = StResp;
          if (owner_q == OwnerData) data_rdata_d = bus_rdata_i;
          else                      inst_rdata_d = bus_rdata_i;
        end
      end
      // No grant in RESP, so the request just serviced cannot be taken twice.
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= OwnerInst;
      addr_q       <= '0;
      wen_q        <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    inst_done_o  = (state_q == StResp) && (owner_q == OwnerInst);
    data_done_o  = (state_q == StResp) && (owner_q == OwnerData);
    inst_stall_o = inst_en_i & ~inst_done_o;
    data_stall_o = data_en_i & ~data_done_o;
    inst_rdata_o = inst_rdata_q;
    data_rdata_o = data_rdata_q;
    bus_req_o    = (state_q == StAddr);
    bus_wr_o     = |wen_q;
    bus_wstrb_o  = wen_q;
    bus_addr_o   = addr_q;
    bus_wdata_o  = wdata_q;
    bus_err_o    = err_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: the bench plays the bus slave and predicts each
// transaction from the arbitration, latency and watchdog rules.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned T  = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          inst_en = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic [DW-1:0] inst_rdata;
  logic          inst_done, inst_stall;
  logic          data_en = 1'b0;
  logic [SW-1:0] data_wen = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic [DW-1:0] data_rdata;
  logic          data_done, data_stall;
  logic          bus_req, bus_wr;
  logic [SW-1:0] bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok = 1'b0;
  logic          bus_data_ok = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_err;

  int checks = 0;
  int failures = 0;

  // Reference state: last word returned to each port and the sticky error flag.
  logic [DW-1:0] m_inst_rdata = '0;
  logic [DW-1:0] m_data_rdata = '0;
  logic          m_err = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .inst_en_i    (inst_en),
    .inst_addr_i  (inst_addr),
    .inst_rdata_o (inst_rdata),
    .inst_done_o  (inst_done),
    .inst_stall_o (inst_stall),
    .data_en_i    (data_en),
    .data_wen_i   (data_wen),
    .data_addr_i  (data_addr),
    .data_wdata_i (data_wdata),
    .data_rdata_o (data_rdata),
    .data_done_o  (data_done),
    .data_stall_o (data_stall),
    .bus_req_o    (bus_req),
    .bus_wr_o     (bus_wr),
    .bus_wstrb_o  (bus_wstrb),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .bus_addr_ok_i(bus_addr_ok),
    .bus_data_ok_i(bus_data_ok),
    .bus_rdata_i  (bus_rdata),
    .bus_err_o    (bus_err)
  );

  // Called #1 after a posedge with the DUT idle. Raises the requested ports, then
  // runs one granted transaction: addr_ok after la wait cycles, data_ok after ld.
  task automatic txn(input bit raise_inst, input bit raise_data, input int la, input int ld,
                     input logic [DW-1:0] rd, input logic [SW-1:0] wen,
                     input logic [AW-1:0] iaddr, input logic [AW-1:0] daddr,
                     input logic [DW-1:0] wdata);
    bit                   is_data, tmo;
    int                   a, d, e;
    logic [AW+1+SW+DW-1:0] exp_bus;
    logic [5:0]           exp_ctrl;
    bit                   idone, ddone;
    if (raise_inst) begin
      inst_en = 1'b1;
      inst_addr = iaddr;
    end
    if (raise_data) begin
      data_en = 1'b1;
      data_addr = daddr;
      data_wen = wen;
      data_wdata = wdata;
    end
    is_data = data_en;
    exp_bus = is_data ? {data_addr, |data_wen, data_wen, data_wdata}
                      : {inst_addr, 1'b0, {SW{1'b0}}, {DW{1'b0}}};
    a = la + 1;
    d = ld + 1;
    tmo = (T != 0) && (a + d >= T);
    e = tmo ? T + 1 : a + d + 1;
    @(posedge clk);
    for (int k = 1; k <= e; k++) begin
      #1;
      if (k < e) begin
        bus_addr_ok = (k == a);
        bus_data_ok = (k <= a) ? 1'b1 : (k == a + d);
        bus_rdata = (k == a + d) ? rd : $urandom;
      end else begin
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata = $urandom;
      end
      if (k == 2) begin
        // Post-grant field changes and a dropped enable must not disturb the transfer.
        if (is_data) begin
          data_addr = $urandom;
          data_wdata = $urandom;
          data_wen = SW'($urandom);
          if ($urandom_range(0, 1) == 1) data_en = 1'b0;
        end else begin
          inst_addr = $urandom;
          if ($urandom_range(0, 1) == 1) inst_en = 1'b0;
        end
      end
      if (k == e) begin
        if (is_data) m_data_rdata = tmo ? '0 : rd;
        else         m_inst_rdata = tmo ? '0 : rd;
        if (tmo) m_err = 1'b1;
      end
      @(negedge clk);
      idone = (k == e) && !is_data;
      ddone = (k == e) && is_data;
      exp_ctrl = {(k < e) && (k <= a), idone, ddone, inst_en & ~idone, data_en & ~ddone, m_err};
      checks++;
      if ({bus_req, inst_done, data_done, inst_stall, data_stall, bus_err} !== exp_ctrl) begin
        failures++;
        $display("FAIL ctrl k=%0d req/idone/ddone/istall/dstall/err got=%b exp=%b", k,
                 {bus_req, inst_done, data_done, inst_stall, data_stall, bus_err}, exp_ctrl);
      end
      checks++;
      if ({bus_addr, bus_wr, bus_wstrb, bus_wdata} !== exp_bus) begin
        failures++;
        $display("FAIL bus_fields k=%0d addr/wr/wstrb/wdata got=%h exp=%h", k,
                 {bus_addr, bus_wr, bus_wstrb, bus_wdata}, exp_bus);
      end
      checks++;
      if ({inst_rdata, data_rdata} !== {m_inst_rdata, m_data_rdata}) begin
        failures++;
        $display("FAIL rdata k=%0d inst/data got=%h/%h exp=%h/%h", k, inst_rdata, data_rdata,
                 m_inst_rdata, m_data_rdata);
      end
      if (k < e) @(posedge clk);
    end
    @(posedge clk);
    #1;
    if (is_data) data_en = 1'b0;
    else         inst_en = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, inst_done, data_done, inst_rdata,
         data_rdata, bus_err} !== '0) begin
      failures++;
      $display("FAIL %s outputs got req=%b wr=%b strb=%h addr=%h wdata=%h idone=%b ddone=%b irdata=%h drdata=%h err=%b exp all zero",
               tag, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, inst_done, data_done,
               inst_rdata, data_rdata, bus_err);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    checks++;
    if ({inst_stall, data_stall} !== 2'b00) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=00", {inst_stall, data_stall});
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_read_fetch();
    txn(1'b1, 1'b0, 0, 0, 32'h3C08_0001, '0, 32'hBFC0_0000, '0, '0);
  endtask

  task automatic test_contention();
    txn(1'b1, 1'b1, 0, 1, 32'h1111_2222, 4'b0000, 32'h0000_0100, 32'h8000_0200, 32'h0);
    txn(1'b0, 1'b0, 1, 0, 32'h3333_4444, '0, '0, '0, '0);
  endtask

  task automatic test_byte_store();
    txn(1'b0, 1'b1, 0, 0, 32'hDEAD_BEEF, 4'b0100, '0, 32'h8000_0010, 32'h00AB_0000);
  endtask

  task automatic test_slow_slave();
    txn(1'b1, 1'b0, 4, 6, 32'h5A5A_A5A5, '0, 32'h0040_0000, '0, '0);
  endtask

  task automatic test_timeout();
    txn(1'b0, 1'b1, 40, 0, 32'hFFFF_FFFF, 4'b0000, '0, 32'h8000_0040, '0);
    txn(1'b1, 1'b0, 0, 0, 32'h0BAD_F00D, '0, 32'h0000_0200, '0, '0);
  endtask

  task automatic test_reset_in_data();
    data_en = 1'b1;
    data_addr = 32'h8000_0300;
    data_wen = '0;
    @(posedge clk);
    #1;
    bus_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    bus_addr_ok = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    data_en = 1'b0;
    m_inst_rdata = '0;
    m_data_rdata = '0;
    m_err = 1'b0;
    @(negedge clk);
    check_all_zero("reset_in_data");
    @(posedge clk);
    #1;
    txn(1'b0, 1'b1, 1, 1, 32'h1234_5678, '0, '0, 32'h8000_0304, '0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int unsigned pat;
      logic [SW-1:0] wen;
      pat = $urandom_range(0, 2);
      wen = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
      txn(pat != 1, pat != 0, $urandom_range(0, 9), $urandom_range(0, 9), $urandom, wen,
          $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom);
    end
    for (int n = 0; n < 4 && (inst_en || data_en); n++) begin
      txn(1'b0, 1'b0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, '0, '0, '0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_read_fetch();
    test_contention();
    test_byte_store();
    test_slow_slave();
    test_timeout();
    test_reset_in_data();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
